// File: rtl/instr_sequencer_if.sv
// Host-side bus of the instruction sequencer: program load, run control and the processor-facing issue port.
interface instr_sequencer_if;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [15:0] i_wr_data;
  logic [4:0]  i_prog_len;
  logic        i_start;
  logic        i_proc_done;
  logic [15:0] o_dout;
  logic        o_run;
  logic        o_busy;
  logic        o_finished;
  logic [3:0]  o_pc;
  logic        o_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_prog_len, i_start, i_proc_done,
    input  o_dout, o_run, o_busy, o_finished, o_pc, o_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_prog_len, i_start, i_proc_done,
    output o_dout, o_run, o_busy, o_finished, o_pc, o_err
  );
endinterface

// File: rtl/instr_sequencer.sv
// Feeds a 16-word program to a simple processor one instruction at a time (mv/mvi/add/sub).
// Optional watchdog on the processor handshake: define INSTR_SEQ_TIMEOUT_EN.
module instr_sequencer (
  input logic             i_clock,
  input logic             i_reset,
  instr_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_FIN} state_t;

  localparam logic [2:0] OP_MVI = 3'd1;

  state_t      r_state, w_next;
  logic [15:0] r_mem [16];
  logic [3:0]  r_pc, w_pc_next;
  logic [4:0]  r_len, w_len_next;
  logic        r_err, w_err_next;
  logic [15:0] w_word;
  logic [2:0]  w_op;
  logic        w_last;
  logic        w_wdog_hit;

  assign w_word = r_mem[r_pc];
  assign w_op   = w_word[15:13];
  assign w_last = ({1'b0, r_pc} == (r_len - 5'd1));

`ifdef INSTR_SEQ_TIMEOUT_EN
  logic [7:0] r_wdog;

  // Counter is zero on IMM/WAIT entry (ISSUE always precedes them), so the
  // 255th waiting cycle lands in FIN.
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_wdog <= 8'd0;
    else if (r_state == S_IMM || r_state == S_WAIT)
      r_wdog <= r_wdog + 8'd1;
    else
      r_wdog <= 8'd0;
  end

  assign w_wdog_hit = (r_wdog == 8'd254);
`else
  assign w_wdog_hit = 1'b0;
`endif

  // Program memory is deliberately outside reset so a reset mid-run keeps the program.
  always_ff @(posedge i_clock) begin
    if (bus.i_wr_en && r_state == S_IDLE)
      r_mem[bus.i_wr_addr] <= bus.i_wr_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= 4'd0;
      r_len   <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_len   <= w_len_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_next   = r_pc;
    w_len_next  = r_len;
    w_err_next  = r_err;
    bus.o_dout  = 16'd0;
    bus.o_run   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start && bus.i_prog_len != 5'd0) begin
          w_next     = S_ISSUE;
          w_pc_next  = 4'd0;
          w_err_next = 1'b0;
          w_len_next = (bus.i_prog_len > 5'd16) ? 5'd16 : bus.i_prog_len;
        end
      end
      S_ISSUE: begin
        bus.o_dout = w_word;
        if (w_op[2]) begin
          w_err_next = 1'b1;
          w_next     = S_FIN;
        end else if (w_op == OP_MVI && w_last) begin
          // mvi with no room left for its immediate word
          w_err_next = 1'b1;
          w_next     = S_FIN;
        end else if (w_op == OP_MVI) begin
          bus.o_run = 1'b1;
          w_pc_next = r_pc + 4'd1;
          w_next    = S_IMM;
        end else begin
          bus.o_run = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_IMM, S_WAIT: begin
        bus.o_dout = w_word;
        if (bus.i_proc_done) begin
          if (w_last) begin
            w_next = S_FIN;
          end else begin
            w_pc_next = r_pc + 4'd1;
            w_next    = S_ISSUE;
          end
        end else if (w_wdog_hit) begin
          w_err_next = 1'b1;
          w_next     = S_FIN;
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_finished = (r_state == S_FIN);
  assign bus.o_pc       = r_pc;
  assign bus.o_err      = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: mvi/add flows, error cases, reset mid-run, busy write guard, watchdog.
module tb_instr_sequencer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = a;
    bus.i_wr_data = d;
    step();
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic go(input logic [4:0] len);
    bus.i_prog_len = len;
    bus.i_start    = 1'b1;
    step();
    bus.i_start    = 1'b0;
  endtask

  task automatic done_step();
    bus.i_proc_done = 1'b1;
    step();
    bus.i_proc_done = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst = 1'b1;
    bus.i_wr_en = 1'b0; bus.i_wr_addr = 4'd0; bus.i_wr_data = 16'd0;
    bus.i_prog_len = 5'd0; bus.i_start = 1'b0; bus.i_proc_done = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_run", bus.o_run, 1'b0);
    chk("rst_dout", bus.o_dout, 16'h0);
    chk("rst_pc", bus.o_pc, 4'd0);
    chk("rst_err", bus.o_err, 1'b0);
    chk("rst_fin", bus.o_finished, 1'b0);

    // mvi R0, #5 over two words
    wr(4'd0, 16'h2000);
    wr(4'd1, 16'h0005);
    go(5'd2);
    chk("mvi_issue_run", bus.o_run, 1'b1);
    chk("mvi_issue_dout", bus.o_dout, 16'h2000);
    chk("mvi_issue_busy", bus.o_busy, 1'b1);
    step();
    chk("mvi_imm_run", bus.o_run, 1'b0);
    chk("mvi_imm_dout", bus.o_dout, 16'h0005);
    chk("mvi_imm_pc", bus.o_pc, 4'd1);
    done_step();
    chk("mvi_fin", bus.o_finished, 1'b1);
    chk("mvi_fin_dout", bus.o_dout, 16'h0);
    chk("mvi_err", bus.o_err, 1'b0);
    step();
    chk("mvi_idle_fin", bus.o_finished, 1'b0);
    chk("mvi_idle_busy", bus.o_busy, 1'b0);

    // add R0,R1 with proc_done two cycles after run
    wr(4'd0, 16'h4080);
    go(5'd1);
    chk("add_issue_run", bus.o_run, 1'b1);
    step();
    chk("add_wait0_dout", bus.o_dout, 16'h4080);
    chk("add_wait0_run", bus.o_run, 1'b0);
    step();
    chk("add_wait1_dout", bus.o_dout, 16'h4080);
    chk("add_wait1_fin", bus.o_finished, 1'b0);
    done_step();
    chk("add_fin", bus.o_finished, 1'b1);
    step();

    // mvi as the last word
    wr(4'd0, 16'h2000);
    go(5'd1);
    chk("mvilast_run", bus.o_run, 1'b0);
    step();
    chk("mvilast_fin", bus.o_finished, 1'b1);
    chk("mvilast_err", bus.o_err, 1'b1);
    step();
    chk("mvilast_sticky", bus.o_err, 1'b1);

    // start with prog_len 0 is ignored
    go(5'd0);
    chk("len0_busy", bus.o_busy, 1'b0);
    chk("len0_err", bus.o_err, 1'b1);

    // illegal opcode
    wr(4'd0, 16'hE000);
    go(5'd1);
    chk("illop_run", bus.o_run, 1'b0);
    step();
    chk("illop_err", bus.o_err, 1'b1);
    chk("illop_fin", bus.o_finished, 1'b1);
    step();

    // reset in WAIT at pc 3 of a 6-word run
    for (int i = 0; i < 6; i++) wr(i[3:0], (i == 2) ? 16'h6123 : 16'h4080);
    go(5'd6);
    chk("clr_err", bus.o_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("r6_pc", bus.o_pc, i[15:0]);
      step();
      done_step();
    end
    step();
    chk("r6_wait_pc3", bus.o_pc, 4'd3);
    go(5'd1);
    chk("busy_start_pc", bus.o_pc, 4'd3);
    chk("busy_start_busy", bus.o_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", bus.o_busy, 1'b0);
    chk("mr_run", bus.o_run, 1'b0);
    chk("mr_dout", bus.o_dout, 16'h0);
    chk("mr_pc", bus.o_pc, 4'd0);
    chk("mr_fin", bus.o_finished, 1'b0);

    // restart from pc 0; a write to mem[2] while busy must be dropped
    go(5'd6);
    chk("rs_pc0", bus.o_pc, 4'd0);
    chk("rs_dout0", bus.o_dout, 16'h4080);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd2; bus.i_wr_data = 16'hFFFF;
    step();
    bus.i_wr_en = 1'b0;
    done_step();
    for (int i = 1; i < 6; i++) begin
      chk("rs_pc", bus.o_pc, i[15:0]);
      chk("rs_dout", bus.o_dout, (i == 2) ? 16'h6123 : 16'h4080);
      step();
      done_step();
    end
    chk("rs_fin", bus.o_finished, 1'b1);
    chk("rs_err", bus.o_err, 1'b0);
    step();

    // prog_len 20 clamps to 16 words
    for (int i = 0; i < 16; i++) wr(i[3:0], 16'h0000);
    go(5'd20);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("cl_pc", bus.o_pc, i[15:0]);
      done_step();
    end
    chk("cl_fin", bus.o_finished, 1'b1);
    step();
    chk("cl_idle", bus.o_busy, 1'b0);

    // processor never answers
    wr(4'd0, 16'h4080);
    go(5'd1);
    step();
`ifdef INSTR_SEQ_TIMEOUT_EN
    repeat (254) step();
    chk("wd_pre_fin", bus.o_finished, 1'b0);
    chk("wd_pre_busy", bus.o_busy, 1'b1);
    step();
    chk("wd_fin", bus.o_finished, 1'b1);
    chk("wd_err", bus.o_err, 1'b1);
    step();
`else
    repeat (300) step();
    chk("nowd_busy", bus.o_busy, 1'b1);
    chk("nowd_fin", bus.o_finished, 1'b0);
    chk("nowd_err", bus.o_err, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
    chk("end_idle", bus.o_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
